string_fifo_avalon: RTL and testbench

- Multi-channel, parametrised Avalon-MM slave FIFO bank that buffers string words between the Nios II and the string accelerator datapath.
- Each channel is an independent circular FIFO with a data port and a status/control register.
- Adds full-depth counting, sticky overflow/underflow flags, flush and flag-clear, a registered read path, and per-channel level outputs for the datapath.

---
 rtl/string_fifo_pkg.sv | 18 +
 rtl/string_fifo_avalon_fifo_channel.sv | 72 +++++++
 rtl/string_fifo_avalon.sv | 107 ++++++++++
 tb/tb_string_fifo_avalon.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/string_fifo_pkg.sv
// Shared constants for the string FIFO bank: register offsets and bit positions.
package string_fifo_pkg;

    // Word offset of each register inside a channel's two-word window
    localparam int DATA_OFS = 0;
    localparam int STAT_OFS = 1;

    // STATUS read-back bit positions
    localparam int EMPTY_BIT = 16;
    localparam int FULL_BIT  = 17;
    localparam int OVF_BIT   = 18;
    localparam int UNF_BIT   = 19;

    // STATUS write (control) bit positions
    localparam int FLUSH_BIT = 0;
    localparam int CLR_BIT   = 1;

endpackage

// File: rtl/string_fifo_avalon_fifo_channel.sv
// One circular FIFO channel with explicit occupancy count and sticky error flags.
// rdata is the combinational head word; the top registers it on a pop.
module fifo_channel #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic              clr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              full,
    output logic              ovf,
    output logic              unf
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));
    assign rdata = mem[rd_ptr];

    // Storage write; contents are intentionally left unreset
    always_ff @(posedge clk) begin
        if (push && !full && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointer and count update; only one of push/pop/flush is active per cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (push && !full) begin
            wr_ptr <= wr_ptr + 1'b1;
            count  <= count + 1'b1;
        end else if (pop && !empty) begin
            rd_ptr <= rd_ptr + 1'b1;
            count  <= count - 1'b1;
        end
    end

    // Sticky error flags; a clear in the same cycle beats a new set
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf <= 1'b0;
            unf <= 1'b0;
        end else if (clr) begin
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            ovf <= ovf | (push & full);
            unf <= unf | (pop & empty);
        end
    end

endmodule

// File: rtl/string_fifo_avalon.sv
// Avalon-MM slave bank of NUM_CH string FIFOs. Channel c owns DATA at 2c and
// STATUS at 2c+1; readdata is registered with one cycle of latency.
// Handshake: an access is a single cycle qualified by chipselect; a write wins
// over a simultaneous read, and readdata only changes on an accepted read.
module string_fifo_avalon
    import string_fifo_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 3,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    chipselect,
    input  logic                    read,
    input  logic                    write,
    input  logic [ADDR_W-1:0]       address,
    input  logic [31:0]             writedata,
    output logic [31:0]             readdata,
    output logic [NUM_CH*CNT_W-1:0] ch_count,
    output logic [NUM_CH-1:0]       ch_empty,
    output logic [NUM_CH-1:0]       ch_full
);

    localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W + 1)'(2 * NUM_CH);

    logic              wr_acc;
    logic              rd_acc;
    logic              addr_ok;
    logic              is_stat;
    logic [ADDR_W-1:0] ch_idx;
    logic [31:0]       rd_next;

    logic [DATA_W-1:0] ch_rdata [NUM_CH];
    logic [CNT_W-1:0]  ch_cnt   [NUM_CH];
    logic [NUM_CH-1:0] ch_ovf;
    logic [NUM_CH-1:0] ch_unf;
    logic [31:0]       ch_stat  [NUM_CH];

    assign wr_acc  = chipselect & write;
    assign rd_acc  = chipselect & read & ~write;
    assign addr_ok = ({1'b0, address} < ADDR_LIMIT);
    assign is_stat = (address[0] == 1'(STAT_OFS));
    assign ch_idx  = address >> 1;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic sel;
        assign sel = addr_ok && (ch_idx == ADDR_W'(c));

        fifo_channel #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_ch (
            .clk   (clk),
            .reset (reset),
            .push  (wr_acc & sel & ~is_stat),
            .pop   (rd_acc & sel & ~is_stat),
            .flush (wr_acc & sel & is_stat & writedata[FLUSH_BIT]),
            .clr   (wr_acc & sel & is_stat & writedata[CLR_BIT]),
            .wdata (writedata[DATA_W-1:0]),
            .rdata (ch_rdata[c]),
            .count (ch_cnt[c]),
            .empty (ch_empty[c]),
            .full  (ch_full[c]),
            .ovf   (ch_ovf[c]),
            .unf   (ch_unf[c])
        );

        assign ch_count[c*CNT_W +: CNT_W] = ch_cnt[c];

        // Status word assembly for this channel
        always_comb begin
            ch_stat[c]            = '0;
            ch_stat[c][CNT_W-1:0] = ch_cnt[c];
            ch_stat[c][EMPTY_BIT] = ch_empty[c];
            ch_stat[c][FULL_BIT]  = ch_full[c];
            ch_stat[c][OVF_BIT]   = ch_ovf[c];
            ch_stat[c][UNF_BIT]   = ch_unf[c];
        end
    end

    // Read mux: unmapped addresses and empty pops return zero
    always_comb begin
        rd_next = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (addr_ok && (ch_idx == ADDR_W'(c))) begin
                if (is_stat) begin
                    rd_next = ch_stat[c];
                end else if (!ch_empty[c]) begin
                    rd_next = 32'(ch_rdata[c]);
                end
            end
        end
    end

    // Registered read data, updated only on an accepted read
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            readdata <= '0;
        end else if (rd_acc) begin
            readdata <= rd_next;
        end
    end

endmodule

// File: tb/tb_string_fifo_avalon.sv
// Directed bench for string_fifo_avalon with a queue-based read scoreboard.
module tb_string_fifo_avalon;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 8;
    localparam int NUM_CH = 2;
    localparam int ADDR_W = 3;
    localparam int CNT_W  = 4;

    logic                    clk = 1'b0;
    logic                    reset = 1'b0;
    logic                    chipselect = 1'b0;
    logic                    read = 1'b0;
    logic                    write = 1'b0;
    logic [ADDR_W-1:0]       address = '0;
    logic [31:0]             writedata = '0;
    logic [31:0]             readdata;
    logic [NUM_CH*CNT_W-1:0] ch_count;
    logic [NUM_CH-1:0]       ch_empty;
    logic [NUM_CH-1:0]       ch_full;

    logic [31:0]       exp_q [$];
    logic [ADDR_W-1:0] adr_q [$];
    logic              rd_seen = 1'b0;
    int n_tests = 0;
    int n_fail  = 0;

    string_fifo_avalon #(
        .DATA_W (DATA_W), .DEPTH (DEPTH), .NUM_CH (NUM_CH), .ADDR_W (ADDR_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .chipselect (chipselect),
        .read       (read),
        .write      (write),
        .address    (address),
        .writedata  (writedata),
        .readdata   (readdata),
        .ch_count   (ch_count),
        .ch_empty   (ch_empty),
        .ch_full    (ch_full)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // monitor: a read accepted at a posedge has its data visible at the next negedge
    always @(posedge clk) rd_seen <= chipselect & read & ~write & reset;

    always @(negedge clk) begin
        if (rd_seen) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL readdata: unexpected read result 0x%08h", readdata);
            end else begin
                logic [31:0]       e;
                logic [ADDR_W-1:0] a;
                e = exp_q.pop_front();
                a = adr_q.pop_front();
                check($sformatf("readdata@addr%0d", a), readdata, e);
            end
        end
    end

    // drivers: set the bus at a negedge and hold it for one clock
    task automatic bus(input logic cs, input logic rd, input logic wr,
                       input logic [ADDR_W-1:0] a, input logic [31:0] d);
        chipselect = cs;
        read       = rd;
        write      = wr;
        address    = a;
        writedata  = d;
        @(negedge clk);
    endtask

    task automatic idle();
        bus(1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        bus(1'b1, 1'b0, 1'b1, a, d);
    endtask

    task automatic rd(input logic [ADDR_W-1:0] a, input logic [31:0] exp);
        exp_q.push_back(exp);
        adr_q.push_back(a);
        bus(1'b1, 1'b1, 1'b0, a, '0);
    endtask

    initial begin
        // reset, then mid-stream reset after a push
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        wr(0, 32'h55);
        wr(2, 32'h66);
        idle();
        #2 reset = 1'b0;
        #1;
        check("reset_readdata", readdata, 32'h0);
        check("reset_ch_empty", {30'd0, ch_empty}, 32'h3);
        check("reset_ch_full", {30'd0, ch_full}, 32'h0);
        check("reset_ch_count", {24'd0, ch_count}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        rd(1, 32'h0001_0000);
        rd(3, 32'h0001_0000);

        // basic push/pop on ch0
        wr(0, 32'h11);
        wr(0, 32'h22);
        wr(0, 32'h33);
        check("ch0_count_3", {24'd0, ch_count}, 32'h03);
        rd(0, 32'h11);
        rd(0, 32'h22);
        rd(0, 32'h33);
        rd(1, 32'h0001_0000);

        // fill ch1, overflow, drain
        for (int i = 0; i < 8; i++) wr(2, 32'hA0 + i);
        check("ch1_full_flag", {30'd0, ch_full}, 32'h2);
        rd(3, 32'h0002_0008);
        wr(2, 32'hFF);
        rd(3, 32'h0006_0008);
        for (int i = 0; i < 8; i++) rd(2, 32'hA0 + i);
        rd(3, 32'h0005_0000);
        wr(3, 32'h2);
        rd(3, 32'h0001_0000);

        // pointer wrap on ch0
        for (int i = 0; i < 6; i++) wr(0, 32'h100 + i);
        for (int i = 0; i < 6; i++) rd(0, 32'h100 + i);
        for (int i = 0; i < 5; i++) wr(0, 32'h200 + i);
        for (int i = 0; i < 5; i++) rd(0, 32'h200 + i);
        rd(1, 32'h0001_0000);

        // underflow and clear
        rd(0, 32'h0);
        rd(1, 32'h0009_0000);
        wr(1, 32'h2);
        rd(1, 32'h0001_0000);

        // flush one channel, other unaffected; unmapped address
        for (int i = 0; i < 4; i++) wr(0, 32'hB0 + i);
        for (int i = 0; i < 4; i++) wr(2, 32'hC0 + i);
        check("both_count_4", {24'd0, ch_count}, 32'h44);
        wr(1, 32'h1);
        check("flush_count", {24'd0, ch_count}, 32'h40);
        rd(1, 32'h0001_0000);
        rd(3, 32'h0000_0004);
        wr(6, 32'hDEAD);
        rd(6, 32'h0);
        rd(3, 32'h0000_0004);
        for (int i = 0; i < 4; i++) rd(2, 32'hC0 + i);

        // read+write together: write wins, readdata holds
        bus(1'b1, 1'b1, 1'b1, 2, 32'h77);
        check("rw_readdata_hold", readdata, 32'hC3);
        check("rw_push_count", {24'd0, ch_count}, 32'h10);
        // chipselect low: no state change, readdata holds
        bus(1'b0, 1'b1, 1'b1, 2, 32'h88);
        check("nocs_count", {24'd0, ch_count}, 32'h10);
        check("nocs_readdata", readdata, 32'hC3);
        rd(2, 32'h77);
        rd(3, 32'h0001_0000);

        idle();
        idle();
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
